fp_addsub_rne: RTL and testbench

// - Parametrised IEEE-754 adder/subtractor. Next generation of the single-precision adder.
// - Adds an op select, round-to-nearest-even with guard/round/sticky bits, and special-value handling.
// - Also adds exception flags and a generic exponent/mantissa split (half, single, double).
// - Multi-cycle FSM. Sits behind the strt/valid/busy handshake used by the other arithmetic cores.

---
 rtl/fp_defs.sv | 31 +++
 rtl/fp_lzc.sv | 17 +
 rtl/fp_addsub_rne.sv | 239 +++++++++++++++++++++++
 tb/tb_fp_addsub_rne.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fp_defs.sv
// Shared definitions for the floating-point arithmetic cores.
package fp_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4
  } fp_state_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_qnan(
    input int exp_w,
    input int man_w
  );
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero count; all-zero input gives WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    cnt
);

  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_rne.sv
// Multi-cycle IEEE-754 add/sub with round-to-nearest-even,
// flush-to-zero denormals and special-value bypass.
module fp_addsub_rne
  import fp_defs::*;
#(
  parameter int EXP = 8,
  parameter int MAN = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               strt,
  input  logic               op,
  input  logic [EXP+MAN:0]   a,
  input  logic [EXP+MAN:0]   b,
  output logic [EXP+MAN:0]   out,
  output logic               valid,
  output logic               busy,
  output logic [3:0]         flags
);

  localparam int W   = EXP + MAN + 1;
  localparam int FW  = MAN + 4;
  localparam int SW  = MAN + 5;
  localparam int XW  = EXP + 2;
  localparam int CW  = $clog2(FW + 1);
  localparam int SHW = $clog2(FW);
  localparam int EMAXI = (1 << EXP) - 1;
  localparam logic [W-1:0]   QNAN = W'(fp_qnan(EXP, MAN));
  localparam logic [EXP-1:0] EMAX = '1;

  fp_state_t state;

  logic           c_sa, c_sb;
  logic [EXP-1:0] c_ea, c_eb;
  logic [MAN-1:0] c_ma, c_mb;

  logic           sp;
  logic [W-1:0]   sp_out;
  logic [3:0]     sp_flg;

  logic           r_sign, r_sub;
  logic [XW-1:0]  r_exp;
  logic [FW-1:0]  r_big, r_sml, r_m;
  logic [SW-1:0]  r_sum;

  logic a_max, b_max, a_nan, b_nan, a_snan, b_snan;
  logic a_inf, b_inf, a_zero, b_zero, a_ge;

  assign a_max  = c_ea == EMAX;
  assign b_max  = c_eb == EMAX;
  assign a_nan  = a_max && (|c_ma);
  assign b_nan  = b_max && (|c_mb);
  assign a_snan = a_nan && !c_ma[MAN-1];
  assign b_snan = b_nan && !c_mb[MAN-1];
  assign a_inf  = a_max && !(|c_ma);
  assign b_inf  = b_max && !(|c_mb);
  assign a_zero = c_ea == '0;
  assign b_zero = c_eb == '0;
  assign a_ge   = {c_ea, c_ma} >= {c_eb, c_mb};

  logic [EXP-1:0]  e_big, e_sml, d;
  logic [MAN-1:0]  m_big, m_sml;
  logic            s_big;
  logic [SHW-1:0]  sh;
  logic [2*FW-1:0] wide;
  logic [FW-1:0]   sml_al;
  logic            sp_n;
  logic [W-1:0]    sp_o;
  logic [3:0]      sp_f;

  always_comb begin
    e_big = a_ge ? c_ea : c_eb;
    e_sml = a_ge ? c_eb : c_ea;
    m_big = a_ge ? c_ma : c_mb;
    m_sml = a_ge ? c_mb : c_ma;
    s_big = a_ge ? c_sa : c_sb;
    d     = e_big - e_sml;
    sh    = (d > EXP'(FW - 1)) ? SHW'(FW - 1) : SHW'(d);
    wide  = {1'b1, m_sml, 3'b000, FW'(0)} >> sh;
    sml_al = wide[2*FW-1:FW] |
             {{(FW-1){1'b0}}, |wide[FW-1:0]};
  end

  always_comb begin
    sp_n = 1'b1;
    sp_o = '0;
    sp_f = '0;
    if (a_nan || b_nan) begin
      sp_o = QNAN;
      sp_f[FLG_INV] = a_snan || b_snan;
    end else if (a_inf && b_inf && (c_sa != c_sb)) begin
      sp_o = QNAN;
      sp_f[FLG_INV] = 1'b1;
    end else if (a_inf) begin
      sp_o = {c_sa, EMAX, {MAN{1'b0}}};
    end else if (b_inf) begin
      sp_o = {c_sb, EMAX, {MAN{1'b0}}};
    end else if (a_zero && b_zero) begin
      sp_o = {c_sa & c_sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      sp_o = {c_sb, c_eb, c_mb};
    end else if (b_zero) begin
      sp_o = {c_sa, c_ea, c_ma};
    end else begin
      sp_n = 1'b0;
    end
  end

  logic [SW-1:0] sum;
  assign sum = r_sub ? ({1'b0, r_big} - {1'b0, r_sml})
                     : ({1'b0, r_big} + {1'b0, r_sml});

  logic [CW-1:0] lz;
  logic          n_zero, n_unf;
  logic [FW-1:0] n_m;
  logic [XW-1:0] n_exp;

  fp_lzc #(.WIDTH(FW)) u_lzc (
    .din (r_sum[FW-1:0]),
    .cnt (lz)
  );

  assign n_zero = !(|r_sum);
  // Normalising past exponent 1 would leave a denormal: flush it.
  assign n_unf  = !r_sum[SW-1] && (XW'(lz) >= r_exp);

  always_comb begin
    if (r_sum[SW-1]) begin
      n_m   = r_sum[SW-1:1] | {{(FW-1){1'b0}}, r_sum[0]};
      n_exp = r_exp + XW'(1);
    end else begin
      n_m   = r_sum[FW-1:0] << lz;
      n_exp = r_exp - XW'(lz);
    end
  end

  logic           up, ovf;
  logic [MAN+1:0] mr;
  logic [XW-1:0]  rexp;
  logic [MAN-1:0] man_r;
  logic [W-1:0]   rnd_out;
  logic [3:0]     rnd_flg;

  always_comb begin
    up    = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
    mr    = {1'b0, r_m[FW-1:3]} + {{(MAN+1){1'b0}}, up};
    rexp  = r_exp + {{(XW-1){1'b0}}, mr[MAN+1]};
    man_r = mr[MAN+1] ? mr[MAN:1] : mr[MAN-1:0];
    ovf   = rexp >= XW'(EMAXI);
    rnd_flg = '0;
    rnd_flg[FLG_OVF] = ovf;
    rnd_flg[FLG_INX] = ovf | r_m[2] | r_m[1] | r_m[0];
    if (ovf) rnd_out = {r_sign, EMAX, {MAN{1'b0}}};
    else     rnd_out = {r_sign, rexp[EXP-1:0], man_r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      out    <= '0;
      flags  <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      c_sa   <= 1'b0;
      c_sb   <= 1'b0;
      c_ea   <= '0;
      c_eb   <= '0;
      c_ma   <= '0;
      c_mb   <= '0;
      sp     <= 1'b0;
      sp_out <= '0;
      sp_flg <= '0;
      r_sign <= 1'b0;
      r_sub  <= 1'b0;
      r_exp  <= '0;
      r_big  <= '0;
      r_sml  <= '0;
      r_sum  <= '0;
      r_m    <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) begin
            c_sa  <= a[W-1];
            c_ea  <= a[W-2:MAN];
            c_ma  <= a[MAN-1:0];
            c_sb  <= b[W-1] ^ op;
            c_eb  <= b[W-2:MAN];
            c_mb  <= b[MAN-1:0];
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sp     <= sp_n;
          sp_out <= sp_o;
          sp_flg <= sp_f;
          r_sign <= s_big;
          r_sub  <= c_sa != c_sb;
          r_exp  <= XW'(e_big);
          r_big  <= {1'b1, m_big, 3'b000};
          r_sml  <= sml_al;
          state  <= ADD;
        end
        ADD: begin
          r_sum <= sum;
          state <= NORM;
        end
        NORM: begin
          if (!sp) begin
            if (n_zero) begin
              sp     <= 1'b1;
              sp_out <= '0;
              sp_flg <= '0;
            end else if (n_unf) begin
              sp     <= 1'b1;
              sp_out <= {r_sign, {(W-1){1'b0}}};
              sp_flg <= 4'b0011;
            end else begin
              r_m   <= n_m;
              r_exp <= n_exp;
            end
          end
          state <= ROUND;
        end
        ROUND: begin
          out   <= sp ? sp_out : rnd_out;
          flags <= sp ? sp_flg : rnd_flg;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_rne.sv
// Directed-vector bench for fp_addsub_rne (single and half).
module tb_fp_addsub_rne;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        strt = 1'b0, op = 1'b0;
  logic [31:0] a = '0, b = '0, out;
  logic        valid, busy;
  logic [3:0]  flags;

  logic        strt_h = 1'b0, op_h = 1'b0;
  logic [15:0] a_h = '0, b_h = '0, out_h;
  logic        valid_h, busy_h;
  logic [3:0]  flags_h;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_addsub_rne #(.EXP(8), .MAN(23)) dut (
    .clk(clk), .rst(rst), .strt(strt), .op(op),
    .a(a), .b(b), .out(out), .valid(valid),
    .busy(busy), .flags(flags)
  );

  fp_addsub_rne #(.EXP(5), .MAN(10)) dut_h (
    .clk(clk), .rst(rst), .strt(strt_h), .op(op_h),
    .a(a_h), .b(b_h), .out(out_h), .valid(valid_h),
    .busy(busy_h), .flags(flags_h)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic run_s(input logic [31:0] ia, input logic [31:0] ib,
                       input logic iop, output logic [31:0] ro,
                       output logic [3:0] rf, output int lat);
    a = ia; b = ib; op = iop; strt = 1'b1;
    @(posedge clk); #1 strt = 1'b0;
    lat = 99; ro = '0; rf = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = n; ro = out; rf = flags;
        break;
      end
    end
  endtask

  task automatic run_h(input logic [15:0] ia, input logic [15:0] ib,
                       input logic iop, output logic [15:0] ro,
                       output int lat);
    a_h = ia; b_h = ib; op_h = iop; strt_h = 1'b1;
    @(posedge clk); #1 strt_h = 1'b0;
    lat = 99; ro = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (valid_h) begin
        lat = n; ro = out_h;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] ro;
    logic [15:0] rh;
    logic [3:0]  rf;
    int          lat, nv;

    // {a, b, op, result, {inv,ovf,unf,inx}}
    tv.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
    tv.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000});
    tv.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
    tv.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000});
    tv.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001});
    tv.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001});
    tv.push_back('{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001});
    tv.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101});
    tv.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011});
    tv.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000});
    tv.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
    tv.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000});
    tv.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000});
    tv.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000});
    tv.push_back('{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000});
    tv.push_back('{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000});
    tv.push_back('{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0000});
    tv.push_back('{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001});

    repeat (3) @(posedge clk);
    #1;
    chk("rst out", 64'(out), 64'h0);
    chk("rst flags", 64'(flags), 64'h0);
    chk("rst valid", 64'(valid), 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst out_h", 64'(out_h), 64'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      run_s(tv[i].a, tv[i].b, tv[i].op, ro, rf, lat);
      chk($sformatf("v%0d out", i), 64'(ro), 64'(tv[i].r));
      chk($sformatf("v%0d flags", i), 64'(rf), 64'(tv[i].f));
      chk($sformatf("v%0d lat", i), 64'(lat), 64'd4);
    end

    // strt held during busy must not start a second op
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h40000000; op = 1'b0; strt = 1'b1;
    @(posedge clk); #1;
    chk("busy set", 64'(busy), 64'h1);
    a = 32'h40000000;
    repeat (3) @(posedge clk);
    #1 strt = 1'b0;
    nv = 0; ro = '0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        nv++; ro = out;
      end
    end
    chk("busy ignore count", 64'(nv), 64'd1);
    chk("busy ignore out", 64'(ro), 64'h40400000);
    chk("busy clear", 64'(busy), 64'h0);

    // reset asserted while the op is in NORM
    a = 32'h40000000; b = 32'h40000000; op = 1'b0; strt = 1'b1;
    @(posedge clk); #1 strt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst out", 64'(out), 64'h0);
    chk("midrst busy", 64'(busy), 64'h0);
    chk("midrst valid", 64'(valid), 64'h0);
    @(negedge clk) rst = 1'b1;
    nv = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    chk("midrst no valid", 64'(nv), 64'd0);
    run_s(32'h3F800000, 32'h40000000, 1'b0, ro, rf, lat);
    chk("post rst out", 64'(ro), 64'h40400000);
    chk("post rst lat", 64'(lat), 64'd4);

    // half precision
    run_h(16'h3C00, 16'h3C00, 1'b0, rh, lat);
    chk("half 1+1", 64'(rh), 64'h4000);
    chk("half lat", 64'(lat), 64'd4);
    run_h(16'h3C00, 16'h4000, 1'b0, rh, lat);
    chk("half 1+2", 64'(rh), 64'h4200);
    run_h(16'h4200, 16'h3C00, 1'b1, rh, lat);
    chk("half 3-1", 64'(rh), 64'h4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
